// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one fifo write port among
// NREQ requesters. A grant lasts for at most BURST back-to-back words, and
// every grant is followed by one IDLE cycle.
// Optional feature macro: FIFO_ARB_STATS_EN adds the xfer_cnt output, which
// holds one saturating per-requester count of accepted words.
module fifo_wr_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_write,
  output logic [WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]       xfer_cnt
`endif
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  owner, owner_nxt;
  logic [IDW-1:0]  last_owner, last_owner_nxt;
  logic [3:0]      burst_cnt, burst_cnt_nxt;
  logic [IDW-1:0]  pick;
  logic            owner_valid;
  logic            xfer;
  logic [WIDTH-1:0] slice [NREQ];

  // Split the flat data bus into one word per requester.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      slice[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin pick: the first valid requester after last_owner, wrapping.
  always_comb begin
    logic [IDW:0] sum;
    logic         found;
    pick  = last_owner;
    found = 1'b0;
    sum   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, last_owner} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      if (!found && req_valid[sum[IDW-1:0]]) begin
        pick  = sum[IDW-1:0];
        found = 1'b1;
      end
    end
  end

  assign owner_valid = req_valid[owner];
  assign xfer        = (state == GRANT) && owner_valid && !fifo_full;

  // Register the FSM state and the arbitration bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IDW'(NREQ-1);
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  // Next-state logic and the combinational fifo/requester-side outputs.
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    burst_cnt_nxt  = burst_cnt;
    req_ready      = '0;
    fifo_write     = 1'b0;
    fifo_data_in   = '0;
    grant_id       = '0;
    busy           = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          owner_nxt     = pick;
          burst_cnt_nxt = '0;
          state_nxt     = GRANT;
        end
      end
      GRANT: begin
        req_ready[owner] = !fifo_full;
        fifo_write       = xfer;
        fifo_data_in     = slice[owner];
        grant_id         = owner;
        busy             = 1'b1;
        if (!owner_valid) begin
          last_owner_nxt = owner;
          state_nxt      = IDLE;
        end else if (xfer) begin
          burst_cnt_nxt = burst_cnt + 4'd1;
          if (burst_cnt + 4'd1 == 4'(BURST)) begin
            last_owner_nxt = owner;
            state_nxt      = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_cnt [NREQ];

  // Saturating count of accepted words for each requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        stat_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && req_valid[i] && (stat_cnt[i] != 16'hFFFF)) begin
          stat_cnt[i] <= stat_cnt[i] + 16'd1;
        end
      end
    end
  end

  // Flatten the counters onto the xfer_cnt bus.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      xfer_cnt[i*16 +: 16] = stat_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized scoreboard bench for fifo_wr_arbiter.
// The driver runs a transaction-level reference model and queues the
// expected per-cycle status and the expected written words. A separate
// monitor pops those queues and compares them with the DUT outputs.
module tb_fifo_wr_arbiter;

  localparam int WIDTH = 16;
  localparam int NREQ  = 4;
  localparam int BURST = 4;
  localparam int IDW   = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*WIDTH-1:0]   req_data;
  logic [NREQ-1:0]         req_ready;
  logic                    fifo_full;
  logic                    fifo_write;
  logic [WIDTH-1:0]        fifo_data_in;
  logic [IDW-1:0]          grant_id;
  logic                    busy;
`ifdef FIFO_ARB_STATS_EN
  logic [NREQ*16-1:0]      xfer_cnt;
`endif

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_write   (fifo_write),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .xfer_cnt     (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREQ-1:0]  ready;
    logic             write;
    logic             busy;
    logic [IDW-1:0]   gid;
    logic [WIDTH-1:0] data;
  } status_t;

  typedef struct packed {
    logic [7:0]       src;
    logic [WIDTH-1:0] data;
  } word_t;

  status_t stat_q[$];
  word_t   word_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model state: current owner (-1 = no grant), words in this
  // grant, previous owner, and each requester's pending word.
  int               m_gnt;
  int               m_cnt;
  int               m_last;
  bit [NREQ-1:0]    pv;
  logic [WIDTH-1:0] pd [NREQ];
  int               m_stats [NREQ];

  bit [NREQ-1:0]    cur_mask;
  int               cur_on;
  int               cur_full;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic driveBus();
    req_valid = pv;
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*WIDTH +: WIDTH] = pd[i];
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NREQ; i++) begin
      if (cur_mask[i] && !pv[i] && ($urandom_range(0, 99) < cur_on)) begin
        pv[i] = 1'b1;
        pd[i] = WIDTH'($urandom);
      end
    end
    driveBus();
    fifo_full = ($urandom_range(0, 99) < cur_full);
  endtask

  task automatic modelCycle();
    status_t       s;
    word_t         w;
    bit [NREQ-1:0] vin;
    bit            ov;
    s   = '0;
    vin = pv;
    ov  = 1'b0;
    if (m_gnt >= 0) begin
      ov     = vin[m_gnt];
      s.busy = 1'b1;
      s.gid  = IDW'(m_gnt);
      s.data = pd[m_gnt];
      if (!fifo_full) s.ready[m_gnt] = 1'b1;
      s.write = ov && !fifo_full;
    end
    stat_q.push_back(s);
    if (s.write) begin
      w.src  = 8'(m_gnt);
      w.data = pd[m_gnt];
      word_q.push_back(w);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (s.ready[i] && vin[i]) begin
        pv[i] = 1'b0;
        if (m_stats[i] < 65535) m_stats[i]++;
      end
    end
    if (m_gnt < 0) begin
      if (vin != '0) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (vin[(m_last + k) % NREQ]) begin
            m_gnt = (m_last + k) % NREQ;
            m_cnt = 0;
            break;
          end
        end
      end
    end else if (!ov) begin
      m_last = m_gnt;
      m_gnt  = -1;
    end else if (s.write) begin
      m_cnt++;
      if (m_cnt == BURST) begin
        m_last = m_gnt;
        m_gnt  = -1;
      end
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    applyStimulus();
    modelCycle();
  endtask

  // Reset with the requesters in mask all holding a word, then check that the
  // first grant goes to the lowest-numbered valid requester.
  task automatic resetPhase(input bit [NREQ-1:0] mask, input int p_on, input int p_full);
    int exp_first;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      pv[i] = mask[i];
      if (mask[i]) pd[i] = WIDTH'($urandom);
    end
    driveBus();
    fifo_full = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_write", fifo_write, 0);
    checkOutput("rst_ready", req_ready, 0);
    m_gnt  = -1;
    m_cnt  = 0;
    m_last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) m_stats[i] = 0;
    cur_mask = mask;
    cur_on   = p_on;
    cur_full = 0;
    @(negedge clk);
    rst = 1'b0;
    modelCycle();
    exp_first = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (mask[i]) exp_first = i;
    end
    stepCycle();
    #3;
    checkOutput("first_grant_id", grant_id, exp_first);
    checkOutput("first_grant_busy", busy, 1);
    cur_full = p_full;
  endtask

  task automatic runCycles(input int n);
    for (int c = 0; c < n; c++) stepCycle();
  endtask

  // Monitor: compare each cycle's status and every fifo write with the queues.
  always @(negedge clk) begin
    status_t e;
    word_t   w;
    #2;
    if (stat_q.size() > 0) begin
      e = stat_q.pop_front();
      checkOutput("req_ready", req_ready, e.ready);
      checkOutput("busy", busy, e.busy);
      checkOutput("fifo_write", fifo_write, e.write);
      if (e.busy) begin
        checkOutput("grant_id", grant_id, e.gid);
        checkOutput("fifo_data_in", fifo_data_in, e.data);
      end
    end
    if (fifo_write === 1'b1) begin
      if (word_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write: got data %0h expected no write", fifo_data_in);
      end else begin
        w = word_q.pop_front();
        checkOutput("wr_data", fifo_data_in, w.data);
        checkOutput("wr_src", grant_id, w.src[IDW-1:0]);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    pv        = '0;
    for (int i = 0; i < NREQ; i++) begin
      pd[i]      = '0;
      m_stats[i] = 0;
    end
    driveBus();
    fifo_full = 1'b0;
    m_gnt     = -1;
    m_cnt     = 0;
    m_last    = NREQ - 1;
    cur_mask  = '0;
    cur_on    = 0;
    cur_full  = 0;
    repeat (2) @(negedge clk);

    $display("[TB] all requesters streaming");
    resetPhase(4'b1111, 100, 0);
    runCycles(30);

    $display("[TB] single requester 2");
    resetPhase(4'b0100, 100, 0);
    runCycles(20);

    $display("[TB] round-robin over 0,1,3");
    resetPhase(4'b1011, 100, 0);
    runCycles(40);

    $display("[TB] random valid with fifo stalls");
    resetPhase(4'b1111, 70, 30);
    runCycles(400);

    $display("[TB] mid-run reset, heavy stalls and early releases");
    resetPhase(4'b1111, 50, 50);
    runCycles(300);

    $display("[TB] sparse requesters");
    resetPhase(4'b0110, 40, 20);
    runCycles(200);

    #4;
    checkOutput("words_left", word_q.size(), 0);
    checkOutput("status_left", stat_q.size(), 0);
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) begin
      checkOutput($sformatf("xfer_cnt%0d", i), xfer_cnt[i*16 +: 16], 16'(m_stats[i]));
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
